// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT frame loader: frame geometry,
// read-FSM encoding and the signed sample type.
package fft_pkg;

    localparam int N      = 128;
    localparam int AW     = 7;
    localparam int DW     = 8;
    localparam int GO_LAT = 2;

    // The GO state lasts GO_LAT-1 cycles; RAM plus output register cover the last two.
    localparam int GO_CW = (GO_LAT > 2) ? $clog2(GO_LAT) : 1;
    localparam logic [GO_CW-1:0] GO_LAST   = GO_CW'(GO_LAT - 2);
    localparam logic [AW:0]      FRAME_LEN = (AW + 1)'(N);
    localparam logic [AW-1:0]    LAST_IDX  = AW'(N - 1);

    localparam logic [3:0] ST_IDLE   = 4'b0001;
    localparam logic [3:0] ST_GO     = 4'b0010;
    localparam logic [3:0] ST_STREAM = 4'b0100;
    localparam logic [3:0] ST_WAIT   = 4'b1000;

    typedef logic signed [DW-1:0] sample_t;

endpackage

// File: rtl/fft_frame_bank.sv
// One N x DW frame buffer: simple dual-port RAM, one write port and one
// registered read port on a single clock.
module fft_frame_bank
    import fft_pkg::*;
(
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  sample_t       wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output sample_t       rd_data
);

    sample_t mem [N];

    // No reset on the array or read register so the tools map this to block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fft_frame_loader.sv
// Ping-pong capture of ADC samples into two frame banks and in-order
// streaming of each full frame into the FFT with a fixed go-to-data latency.
module fft_frame_loader
    import fft_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    in_valid,
    input  sample_t in_data,
    input  logic    ovf_clr,
    input  logic    fft_done,
    output logic    fft_go,
    output sample_t fft_data,
    output logic    ovf,
    output logic    busy
);

    logic [1:0]       full_reg;
    logic [1:0]       full_next;
    logic             wbank_reg;
    logic [AW-1:0]    wptr_reg;
    logic             ovf_reg;

    logic [3:0]       state_reg;
    logic [GO_CW-1:0] go_cnt_reg;
    logic [AW:0]      iss_cnt_reg;
    logic [AW:0]      out_cnt_reg;
    logic             rbank_reg;
    logic             oldest_reg;
    logic             fft_go_reg;
    logic             busy_reg;
    logic             rvalid_reg;
    sample_t          fft_data_reg;

    logic             accept;
    logic             drop;
    logic             wr_last;
    logic             rd_en;
    logic             free_bank;
    sample_t          rd_data [2];

    // Full flags are registered, so a bank freed this cycle still blocks this cycle's sample.
    assign accept    = in_valid && !full_reg[wbank_reg];
    assign drop      = in_valid && full_reg[wbank_reg];
    assign wr_last   = accept && (wptr_reg == LAST_IDX);
    assign free_bank = (state_reg == ST_STREAM) && (out_cnt_reg == FRAME_LEN);

    // Addresses run two cycles ahead of fft_data: one for the RAM, one for the output register.
    assign rd_en = ((state_reg == ST_GO) && (go_cnt_reg == GO_LAST)) ||
                   ((state_reg == ST_STREAM) && !iss_cnt_reg[AW]);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            fft_frame_bank u_bank (
                .clk     (clk),
                .wr_en   (accept && (wbank_reg == 1'(gi))),
                .wr_addr (wptr_reg),
                .wr_data (in_data),
                .rd_en   (rd_en && (rbank_reg == 1'(gi))),
                .rd_addr (iss_cnt_reg[AW-1:0]),
                .rd_data (rd_data[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbank_reg <= 1'b0;
            wptr_reg  <= '0;
        end else if (accept) begin
            wptr_reg <= wptr_reg + 1'b1;
            if (wr_last) begin
                wbank_reg <= ~wbank_reg;
            end
        end
    end

    // The bank being freed is always the other one from the bank being completed.
    always_comb begin
        full_next = full_reg;
        if (free_bank) begin
            full_next[rbank_reg] = 1'b0;
        end
        if (wr_last) begin
            full_next[wbank_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_reg <= '0;
            ovf_reg  <= 1'b0;
        end else begin
            full_reg <= full_next;
            if (drop) begin
                ovf_reg <= 1'b1;
            end else if (ovf_clr) begin
                ovf_reg <= 1'b0;
            end
        end
    end

    // Frames fill the banks alternately, so reading alternately preserves frame order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            go_cnt_reg  <= '0;
            iss_cnt_reg <= '0;
            out_cnt_reg <= '0;
            rbank_reg   <= 1'b0;
            oldest_reg  <= 1'b0;
            fft_go_reg  <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            fft_go_reg <= 1'b0;
            if (rd_en) begin
                iss_cnt_reg <= iss_cnt_reg + 1'b1;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (full_reg[oldest_reg]) begin
                        fft_go_reg  <= 1'b1;
                        busy_reg    <= 1'b1;
                        rbank_reg   <= oldest_reg;
                        oldest_reg  <= ~oldest_reg;
                        go_cnt_reg  <= '0;
                        iss_cnt_reg <= '0;
                        state_reg   <= ST_GO;
                    end
                end
                ST_GO: begin
                    if (go_cnt_reg == GO_LAST) begin
                        out_cnt_reg <= '0;
                        state_reg   <= ST_STREAM;
                    end else begin
                        go_cnt_reg <= go_cnt_reg + 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (out_cnt_reg == FRAME_LEN) begin
                        state_reg <= ST_WAIT;
                    end else begin
                        out_cnt_reg <= out_cnt_reg + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (fft_done) begin
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_reg   <= 1'b0;
            fft_data_reg <= '0;
        end else begin
            rvalid_reg   <= rd_en;
            fft_data_reg <= rvalid_reg ? rd_data[rbank_reg] : '0;
        end
    end

    assign fft_go   = fft_go_reg;
    assign fft_data = fft_data_reg;
    assign ovf      = ovf_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed bench for fft_frame_loader: ramp, ping-pong, overflow, sparse
// input and mid-stream reset, with hand-defined frame patterns.
module tb_fft_frame_loader;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic signed [7:0] in_data;
    logic              ovf_clr;
    logic              fft_done;
    logic              fft_go;
    logic signed [7:0] fft_data;
    logic              ovf;
    logic              busy;

    int vectors     = 0;
    int miscompares = 0;

    fft_frame_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .ovf_clr  (ovf_clr),
        .fft_done (fft_done),
        .fft_go   (fft_go),
        .fft_data (fft_data),
        .ovf      (ovf),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int id, input int k);
        case (id)
            0:       pat = 8'(-(k + 1));
            1:       pat = 8'(k);
            2:       pat = 8'(127 - k);
            3:       pat = 8'(k) ^ 8'h5A;
            4:       pat = 8'(100 - k);
            5:       pat = 8'(k * 3);
            6:       pat = ~8'(k);
            8:       pat = 8'h77;
            9:       pat = 8'(k + 17);
            10:      pat = 8'(k - 64);
            11:      pat = 8'(200 - k);
            default: pat = 8'h00;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic feed(input int id);
        for (int k = 0; k < 128; k++) begin
            in_valid = 1'b1;
            in_data  = pat(id, k);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic done_pulse(input string tag);
        fft_done = 1'b1;
        @(negedge clk);
        fft_done = 1'b0;
        chk({tag, "_busy_clr"}, {7'd0, busy}, 8'd0);
    endtask

    task automatic wait_go(input string tag, input int max_cycles);
        int n = 0;
        while (fft_go !== 1'b1 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_go"}, {7'd0, fft_go}, 8'd1);
    endtask

    // Called on the negedge where fft_go is high (cycle T); sample k is expected at T+2+k.
    task automatic check_stream(input int id, input string tag);
        @(negedge clk);
        chk({tag, "_go_1cyc"}, {7'd0, fft_go}, 8'd0);
        chk({tag, "_pre0"}, fft_data, 8'd0);
        for (int k = 0; k < 128; k++) begin
            @(negedge clk);
            chk($sformatf("%s_s%0d", tag, k), fft_data, pat(id, k));
        end
        @(negedge clk);
        chk({tag, "_post0"}, fft_data, 8'd0);
        chk({tag, "_busy"}, {7'd0, busy}, 8'd1);
    endtask

    initial begin
        logic saw_go;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        ovf_clr  = 1'b0;
        fft_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_go", {7'd0, fft_go}, 8'd0);
        chk("rst_data", fft_data, 8'd0);
        chk("rst_ovf", {7'd0, ovf}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Ramp: go exactly one cycle after the last sample lands
        feed(0);
        chk("ramp_nogo", {7'd0, fft_go}, 8'd0);
        @(negedge clk);
        chk("ramp_go", {7'd0, fft_go}, 8'd1);
        chk("ramp_busy_set", {7'd0, busy}, 8'd1);
        check_stream(0, "ramp");
        repeat (300) @(negedge clk);
        chk("ramp_busy_hold", {7'd0, busy}, 8'd1);
        done_pulse("ramp");
        @(negedge clk);
        chk("ramp_idle_go", {7'd0, fft_go}, 8'd0);

        // Ping-pong: continuous 256 samples while the first frame streams
        fork
            begin
                feed(1);
                feed(2);
            end
            begin
                wait_go("pp_a", 400);
                check_stream(1, "pp_a");
                repeat (50) @(negedge clk);
                done_pulse("pp_a");
                wait_go("pp_b", 10);
                check_stream(2, "pp_b");
                repeat (50) @(negedge clk);
                done_pulse("pp_b");
            end
        join
        chk("pp_ovf", {7'd0, ovf}, 8'd0);

        // Overflow: fill both banks with fft_done withheld, then drop
        feed(3);
        @(negedge clk);
        chk("ovf_a_go", {7'd0, fft_go}, 8'd1);
        check_stream(3, "ovf_a");
        feed(4);
        feed(5);
        chk("ovf_pre", {7'd0, ovf}, 8'd0);
        chk("ovf_nogo", {7'd0, fft_go}, 8'd0);
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = pat(8, k);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("ovf_set", {7'd0, ovf}, 8'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_clr", {7'd0, ovf}, 8'd0);
        in_valid = 1'b1;
        in_data  = pat(8, 0);
        ovf_clr  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        ovf_clr  = 1'b0;
        chk("ovf_drop_wins", {7'd0, ovf}, 8'd1);
        done_pulse("ovf_a");
        wait_go("ovf_b", 5);
        check_stream(4, "ovf_b");
        done_pulse("ovf_b");
        wait_go("ovf_c", 5);
        check_stream(5, "ovf_c");
        feed(9);
        done_pulse("ovf_c");
        wait_go("ovf_e", 5);
        check_stream(9, "ovf_e");
        done_pulse("ovf_e");
        chk("ovf_sticky", {7'd0, ovf}, 8'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_clr2", {7'd0, ovf}, 8'd0);

        // Sparse: one sample every third clock, no go until the frame completes
        saw_go = 1'b0;
        for (int k = 0; k < 128; k++) begin
            if (k > 0) begin
                repeat (2) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                    saw_go = saw_go | fft_go;
                end
            end
            in_valid = 1'b1;
            in_data  = pat(6, k);
            @(negedge clk);
            saw_go = saw_go | fft_go;
        end
        in_valid = 1'b0;
        chk("sparse_nogo", {7'd0, saw_go}, 8'd0);
        @(negedge clk);
        chk("sparse_go", {7'd0, fft_go}, 8'd1);
        check_stream(6, "sparse");
        done_pulse("sparse");

        // Reset mid-stream at sample 40
        feed(10);
        @(negedge clk);
        chk("rms_go", {7'd0, fft_go}, 8'd1);
        repeat (42) @(negedge clk);
        chk("rms_s40", fft_data, pat(10, 40));
        rst_n = 1'b0;
        #1;
        chk("rms_go0", {7'd0, fft_go}, 8'd0);
        chk("rms_data0", fft_data, 8'd0);
        chk("rms_busy0", {7'd0, busy}, 8'd0);
        chk("rms_ovf0", {7'd0, ovf}, 8'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rms_idle", {7'd0, fft_go}, 8'd0);
        chk("rms_idle_data", fft_data, 8'd0);
        feed(11);
        chk("post_nogo", {7'd0, fft_go}, 8'd0);
        @(negedge clk);
        chk("post_go", {7'd0, fft_go}, 8'd1);
        check_stream(11, "post");
        done_pulse("post");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
